// File: rtl/array_packer.sv
// Serial-to-parallel packer: gathers N (a, b) element pairs into two packed
// frames and presents them on a valid/ready output until consumed.
module array_packer #(
    parameter int unsigned N = 10,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           res,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_last,
    output logic [N*W-1:0] num1,
    output logic [N*W-1:0] num2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err,
    output logic [7:0]     frame_cnt
);

    localparam int unsigned NW = N * W;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   index;

    logic            accept_c;
    logic            last_slot_c;
    int unsigned     shift_c;
    logic [NW-1:0]   mask_c;
    logic [NW-1:0]   a_ins_c;
    logic [NW-1:0]   b_ins_c;
    logic [NW-1:0]   num1_nxt_c;
    logic [NW-1:0]   num2_nxt_c;

    assign in_ready    = (state == FILL) && !res;
    assign accept_c    = in_valid && in_ready;
    assign last_slot_c = (index == IW'(N - 1));

    // Slot k lives at the top of the vector for k = 0; the first beat also clears stale slots.
    always_comb begin
        shift_c    = (N - 1 - 32'(index)) * W;
        mask_c     = NW'({W{1'b1}}) << shift_c;
        a_ins_c    = NW'(in_a) << shift_c;
        b_ins_c    = NW'(in_b) << shift_c;
        num1_nxt_c = (num1 & ~mask_c) | a_ins_c;
        num2_nxt_c = (num2 & ~mask_c) | b_ins_c;
        if (index == '0) begin
            num1_nxt_c = a_ins_c;
            num2_nxt_c = b_ins_c;
        end
    end

    // Frame sequencing, packing and delivery bookkeeping.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= FILL;
            index     <= '0;
            num1      <= '0;
            num2      <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            err <= 1'b0;
            case (state)
                FILL: begin
                    if (accept_c) begin
                        num1 <= num1_nxt_c;
                        num2 <= num2_nxt_c;
                        if (last_slot_c) begin
                            state     <= FULL;
                            index     <= '0;
                            out_valid <= 1'b1;
                        end else if (in_last) begin
                            index <= '0;
                            err   <= 1'b1;
                        end else begin
                            index <= index + IW'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/array_packer.md
Name: array_packer

Overview:
- Serial-to-parallel front end that feeds array_sum: accepts element pairs (a, b) one per clock over a valid/ready handshake.
- Packs N pairs into the two packed vectors num1/num2 in array_sum's element order.
- Presents the completed frame with out_valid/out_ready and holds it stable until it is consumed.
- Detects short frames through in_last and counts delivered frames.

Parameters:
- N, 10, elements per frame (N >= 2).
- W, 8, element width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- res  input  1  synchronous active-high reset.
- in_valid  input  1  element pair on in_a/in_b is valid.
- in_ready  output  1  packer can accept a pair this cycle.
- in_a  input  W  element destined for num1.
- in_b  input  W  element destined for num2.
- in_last  input  1  marks the final pair of a frame.
- num1  output  N*W  packed frame A, element 0 in bits [N*W-1 : N*W-W].
- num2  output  N*W  packed frame B, same ordering as num1.
- out_valid  output  1  num1/num2 hold a complete frame.
- out_ready  input  1  consumer accepts the frame.
- err  output  1  one-cycle pulse when a short frame is aborted.
- frame_cnt  output  8  count of frames delivered, wraps 255 -> 0.

Behaviour:
- Reset (res=1 at a rising edge):
  - state = FILL, index = 0.
  - num1 = num2 = 0, out_valid = 0, err = 0, frame_cnt = 0.
  - in_ready = 0 while res is high.
  - Reset mid-frame discards all partial data.
  - Reset while FULL drops the frame without counting it.
- States: FILL, FULL. Register index is 0..N-1, clog2(N) bits.
- Transfer: an input beat is accepted when in_valid && in_ready at a rising edge.
- Output: in_ready = (state==FILL) && !res, combinational. out_valid = (state==FULL), registered.
- FILL, accepted beat with index = k:
  - Slot k of num1 gets in_a; slot k of num2 gets in_b. Slot k = bits [N*W-1-k*W -: W].
  - If k = 0, all other slots of num1 and num2 are cleared in the same edge.
  - If k < N-1 and in_last = 0: index <= k+1, stay in FILL.
  - If k < N-1 and in_last = 1 (short frame):
    - Frame aborted: index <= 0, stay in FILL.
    - err = 1 for exactly the next cycle.
    - num1/num2 contents are don't-care until the next frame starts.
  - If k = N-1, regardless of in_last: state <= FULL, index <= 0.
  - So out_valid rises one cycle after the N-th accept: latency 1 clock from the final beat.
- FILL, no accepted beat: all state is held.
- FULL:
  - num1/num2 are held bit-stable; in_ready = 0.
  - in_valid is ignored, with no side effects.
  - On out_valid && out_ready: state <= FILL, frame_cnt <= frame_cnt + 1 mod 256.
  - The next frame's first beat can be accepted on the following cycle, giving a one-cycle bubble.
- out_valid, once high, stays high until the handshake completes; it is never withdrawn except by reset.
- out_ready is ignored in FILL.
- num1/num2 are meaningful only while out_valid = 1.
- Gaps (in_valid low) are allowed anywhere inside a frame, with no timeout.
- Elements are unsigned W-bit values, copied verbatim with no arithmetic.

Test Plan:
1. Nominal frame: in_valid held high for 10 cycles, in_a = 2,4,6,...,20, in_b = 1,3,5,...,19, in_last on beat 9, out_ready = 1.
   - Required: out_valid high exactly one cycle, starting one clock after beat 9.
   - num1 = 80'h020406080A0C0E101214, num2 = 80'h01030507090B0D0F1113.
   - frame_cnt = 1; in_ready = 0 during the FULL cycle.
2. Backpressure: same frame with out_ready = 0 for 5 cycles after out_valid rises, and in_valid kept high with changing data.
   - Required: num1/num2 unchanged and in_ready = 0 throughout.
   - frame_cnt increments only on the handshake cycle.
3. Short frame: 4 beats with in_last on beat 3, then a full frame with a = 5,4,3,2,1,1,2,3,4,5 and b = 1..10.
   - Required: err pulses once, for one cycle.
   - num1 = 80'h05040302010102030405, num2 = 80'h0102030405060708090A.
   - frame_cnt = 1.
4. Gapped input: in_valid toggled 1,0,1,0 across the 10 beats.
   - Required: same packed output as scenario 1.
   - out_valid follows the 10th accepted beat by one clock.
5. Reset mid-operation:
   - res pulsed after 6 beats: all outputs return to 0; the next 10 beats form a clean frame.
   - res pulsed while FULL: out_valid drops to 0 and frame_cnt stays 0.
6. Counter wrap: 256 back-to-back frames with out_ready = 1.
   - Required: frame_cnt reads 255 after frame 255, then 0 after frame 256; err never asserted.
